// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared widths, zigzag scan order and luminance quantizer tables
package jpeg_pkg;
  localparam int COEF_W_DEF = 8;
  localparam int OUT_W_DEF = 8;
  localparam int RECIP_FRAC_DEF = 16;
  localparam int BLK_W = 64;
  typedef logic [5:0] idx_t;
  localparam idx_t ZZ_NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };
  localparam logic [7:0] QTAB_LUM [64] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };
  // round(65536 / QTAB_LUM[n])
  localparam logic [15:0] RECIP_LUM [64] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662
  };
endpackage

// File: rtl/jpeg_quant_unit.sv
// jpeg_quant_unit: sign/magnitude reciprocal multiply with round-half-away and saturation
module jpeg_quant_unit #(
  parameter int COEF_W = 8,
  parameter int OUT_W = 8,
  parameter int RECIP_FRAC = 16
) (
  input  logic signed [COEF_W-1:0] coef,
  input  logic [15:0]              recip,
  output logic signed [OUT_W-1:0]  q
);
  localparam int PW = COEF_W + 16;
  localparam logic [PW-1:0] RND = PW'(1) << (RECIP_FRAC - 1);
  localparam logic [PW-1:0] MAXQ = PW'((1 << (OUT_W - 1)) - 1);
  logic [COEF_W-1:0] mag;
  logic [PW-1:0] prod, qm;
  logic [OUT_W-1:0] qs;
  always_comb begin
    mag = coef[COEF_W-1] ? COEF_W'(-coef) : COEF_W'(coef);
    prod = PW'(mag) * PW'(recip) + RND;
    qm = prod >> RECIP_FRAC;
    qs = qm > MAXQ ? OUT_W'(MAXQ) : OUT_W'(qm);
    q = coef[COEF_W-1] ? OUT_W'(-qs) : qs;
  end
endmodule

// File: rtl/jpeg_zigzag_quant.sv
// jpeg_zigzag_quant: ping-pong 8x8 block buffer, drained in zigzag order through the quantizer
module jpeg_zigzag_quant
  import jpeg_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int RECIP_FRAC = RECIP_FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*COEF_W-1:0]     in_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_coef,
  output logic [5:0]              out_idx,
  output logic                    out_last
);
  logic [8*COEF_W-1:0] bank_q [2][8];
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [2:0] row_q, row_d;
  idx_t zz_q, zz_d, nat, out_idx_q, out_idx_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [OUT_W-1:0] out_coef_q, out_coef_d, quant;
  logic [8*COEF_W-1:0] rd_row;
  logic signed [COEF_W-1:0] coef;
  logic [15:0] recip;
  logic wr, ld, wr_done, rd_done;

  jpeg_quant_unit #(.COEF_W(COEF_W), .OUT_W(OUT_W), .RECIP_FRAC(RECIP_FRAC)) u_quant (
    .coef(coef),
    .recip(recip),
    .q(quant)
  );

  always_comb begin
    in_ready = !full_q[wr_bank_q];
    wr = in_valid && in_ready;
    ld = (!out_valid_q || out_ready) && full_q[rd_bank_q];
    wr_done = wr && &row_q;
    rd_done = ld && &zz_q;
    nat = ZZ_NAT[zz_q];
    recip = RECIP_LUM[nat];
    rd_row = bank_q[rd_bank_q][nat[5:3]];
    coef = rd_row[nat[2:0]*COEF_W +: COEF_W];
    // write and drain never target the same bank, so set and clear cannot collide
    full_d = (full_q | (wr_done ? 2'b01 << wr_bank_q : 2'b00)) & ~(rd_done ? 2'b01 << rd_bank_q : 2'b00);
    wr_bank_d = wr_bank_q ^ wr_done;
    rd_bank_d = rd_bank_q ^ rd_done;
    row_d = wr ? row_q + 3'd1 : row_q;
    zz_d = ld ? zz_q + 6'd1 : zz_q;
    out_valid_d = ld || (out_valid_q && !out_ready);
    out_coef_d = ld ? quant : out_coef_q;
    out_idx_d = ld ? zz_q : out_idx_q;
    out_last_d = ld ? &zz_q : out_last_q;
  end

  always_ff @(posedge clk)
    if (wr) bank_q[wr_bank_q][row_q] <= in_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      row_q <= '0;
      zz_q <= '0;
      out_valid_q <= 1'b0;
      out_coef_q <= '0;
      out_idx_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      full_q <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      row_q <= row_d;
      zz_q <= zz_d;
      out_valid_q <= out_valid_d;
      out_coef_q <= out_coef_d;
      out_idx_q <= out_idx_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_coef = out_coef_q;
  assign out_idx = out_idx_q;
  assign out_last = out_last_q;
endmodule

// File: tb/tb_jpeg_zigzag_quant.sv
// tb_jpeg_zigzag_quant: table vectors plus streaming/backpressure/reset sequences, queue scoreboard
module tb_jpeg_zigzag_quant;
  import jpeg_pkg::*;
  typedef struct { int nat; int val; int idx; int exp; } vec_t;
  typedef struct { int coef; int idx; int last; } exp_t;

  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last;
  logic [63:0] in_row = '0;
  logic signed [7:0] out_coef;
  logic [5:0] out_idx;

  exp_t sbq[$];
  int cmp_n = 0, err_n = 0;
  int zz_ref [64];
  int rdy_mode = 0;
  bit b2b = 0, started = 0;
  int bubbles = 0;
  vec_t tv [12];
  logic signed [7:0] blk [64];
  logic signed [7:0] rnd_blk [4][64];

  jpeg_zigzag_quant dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef), .out_idx(out_idx),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model(input int c, input int n);
    int qv, r, m, q;
    qv = int'(QTAB_LUM[n]);
    r = (65536 + qv / 2) / qv;
    m = c < 0 ? -c : c;
    q = (m * r + 32768) >>> 16;
    if (q > 127) q = 127;
    return c < 0 ? -q : q;
  endfunction

  task automatic push_block(input logic signed [7:0] b [64]);
    for (int k = 0; k < 64; k++) sbq.push_back('{model(int'(b[zz_ref[k]]), zz_ref[k]), k, int'(k == 63)});
  endtask

  task automatic send_row(input logic [63:0] w);
    int t = 0;
    in_row = w;
    in_valid = 1;
    while (!in_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("in_ready_timeout", int'(in_ready), 1);
    @(negedge clk);
  endtask

  task automatic send_rows(input logic signed [7:0] b [64]);
    logic [63:0] w;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) w[c*8 +: 8] = b[r*8+c];
      send_row(w);
    end
    in_valid = 0;
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (sbq.size() != 0 && t < limit) begin @(negedge clk); t++; end
    chk("drain_left", sbq.size(), 0);
  endtask

  // Scoreboard: every valid cycle is compared against the queue head; pop on handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (b2b) started = 1;
        if (sbq.size() == 0) chk("spurious_valid", int'(out_valid), 0);
        else begin
          chk("coef", int'(out_coef), sbq[0].coef);
          chk("idx", int'(out_idx), sbq[0].idx);
          chk("last", int'(out_last), sbq[0].last);
          if (out_ready) void'(sbq.pop_front());
        end
      end else if (b2b && started && sbq.size() != 0) bubbles++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : ($urandom_range(0, 99) >= 30);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, seen, t;
    k = 0;
    for (int s = 0; s < 15; s++)
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz_ref[k] = r*8 + s - r; k++; end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin zz_ref[k] = r*8 + s - r; k++; end
      end
    tv = '{'{0, -24, 0, -2}, '{0, -128, 0, -8}, '{0, 8, 0, 1}, '{0, -8, 0, -1},
           '{0, 64, 0, 4}, '{1, 22, 1, 2}, '{8, 36, 2, 3}, '{9, -60, 4, -5},
           '{63, 99, 63, 1}, '{0, 127, 0, 8}, '{7, -100, 28, -2}, '{56, 127, 35, 2}};
    for (int b = 0; b < 4; b++)
      for (int n = 0; n < 64; n++) rnd_blk[b][n] = 8'($urandom_range(0, 255));

    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_coef", int'(out_coef), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    repeat (5) @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_out_valid", int'(out_valid), 0);

    // Sparse block with first-output latency check
    for (int n = 0; n < 64; n++) blk[n] = 0;
    blk[0] = 64; blk[1] = 22; blk[8] = 36;
    push_block(blk);
    send_rows(blk);
    chk("latency_early", int'(out_valid), 0);
    @(negedge clk);
    chk("latency_valid", int'(out_valid), 1);
    wait_drain(200);

    // Hand-computed single-coefficient vectors
    for (int i = 0; i < 12; i++) begin
      for (int n = 0; n < 64; n++) blk[n] = 0;
      blk[tv[i].nat] = 8'(tv[i].val);
      for (int j = 0; j < 64; j++) sbq.push_back('{j == tv[i].idx ? tv[i].exp : 0, j, int'(j == 63)});
      send_rows(blk);
      wait_drain(200);
    end

    // Every position unique and non-zero
    for (int n = 0; n < 64; n++) blk[n] = 8'((n * 37 + 11) % 255 - 127);
    push_block(blk);
    send_rows(blk);
    wait_drain(200);

    // Back-to-back streaming
    b2b = 1; started = 0; bubbles = 0;
    for (int b = 0; b < 4; b++) begin
      push_block(rnd_blk[b]);
      send_rows(rnd_blk[b]);
      if (b == 1) chk("both_full_in_ready", int'(in_ready), 0);
    end
    wait_drain(600);
    chk("b2b_bubbles", bubbles, 0);
    b2b = 0;

    // Full stall then random backpressure, same data as the unstalled run
    rdy_mode = 1;
    push_block(rnd_blk[0]);
    send_rows(rnd_blk[0]);
    push_block(rnd_blk[1]);
    send_rows(rnd_blk[1]);
    repeat (5) @(negedge clk);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_valid", int'(out_valid), 1);
    chk("stall_idx", int'(out_idx), 0);
    rdy_mode = 2;
    for (int b = 2; b < 4; b++) begin
      push_block(rnd_blk[b]);
      send_rows(rnd_blk[b]);
    end
    wait_drain(3000);
    rdy_mode = 0;

    // Reset in the middle of a drain
    push_block(blk);
    send_rows(blk);
    t = 0;
    while (!(out_valid && out_idx == 6'd20) && t < 500) begin @(negedge clk); t++; end
    chk("reach_idx20", int'(out_idx), 20);
    reset = 1;
    sbq.delete();
    @(negedge clk);
    reset = 0;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    seen = 0;
    repeat (80) begin @(negedge clk); if (out_valid) seen++; end
    chk("post_rst_outputs", seen, 0);
    push_block(rnd_blk[3]);
    send_rows(rnd_blk[3]);
    wait_drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/jpeg_zigzag_quant.md
Name: jpeg_zigzag_quant

Overview:
- Stage directly downstream of the 2-D DCT core in top_jpeg_test.
- Consumes 8×8 coefficient blocks, one 64-bit row per transfer, in the same row-word layout the DCT writes to MEM_OUT.
- Quantizes each coefficient with the fixed luminance table and emits them one per cycle in zigzag order for the entropy coder.
- Ping-pong buffered, so one block is accepted while the previous one drains.

Parameters:
- COEF_W, 8, signed coefficient width. Row word is 8*COEF_W bits; column c occupies bits [c*COEF_W +: COEF_W].
- OUT_W, 8, signed quantized output width.
- RECIP_FRAC, 16, fractional bits of the reciprocal quantizer constants.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  row word valid.
- in_ready  out  1  stage can accept a row.
- in_row  in  8*COEF_W  one block row, rows arrive 0..7.
- out_valid  out  1  out_coef valid.
- out_ready  in  1  consumer accepts out_coef.
- out_coef  out  OUT_W  quantized coefficient, signed.
- out_idx  out  6  zigzag index 0..63 of out_coef.
- out_last  out  1  high with zigzag index 63.

Behaviour:
- Reset: one clock, synchronous, active-high; it is the only reset in the block.
  - Outputs after reset: in_ready=1, out_valid=0, out_coef=0, out_idx=0, out_last=0.
  - Internal: both bank-full flags cleared, wr_bank=0, rd_bank=0, row counter 0, zigzag counter 0.
- Reset mid-operation:
  - Abandons any partially written or partially drained block; nothing of it is ever emitted.
  - Buffer contents are not cleared; the full flags make them invalid.
- Input transfer:
  - A row is written when in_valid && in_ready at the clock edge; it goes to row rowcnt of bank wr_bank.
  - in_ready = !full[wr_bank].
  - On the 8th row: full[wr_bank] is set, wr_bank toggles and rowcnt wraps to 0.
  - Sustained input rate: 8 rows per 64 output cycles. No throughput loss at the input when the drain keeps up.
- Output stage: a single register stage.
  - It loads when (!out_valid || out_ready) and full[rd_bank].
  - Load source: the coefficient at natural position ZZ[zz] from bank rd_bank, quantized.
  - out_idx = zz, out_last = (zz==63); zz then increments.
  - When zz==63 is loaded: full[rd_bank] is cleared in the same edge, rd_bank toggles and zz wraps to 0.
  - With out_ready low and out_valid high, out_coef, out_idx and out_last are held stable.
  - If the next bank is not full when the current coefficient is taken, out_valid drops.
- Latency: out_valid rises on the edge after the one that accepted row 7, assuming an idle output. There is no gap between back-to-back blocks.
- Quantization:
  - Computation: m=|c|, p=m*RECIP[n] + 2^(RECIP_FRAC-1), q=p>>RECIP_FRAC; the result is q with the sign of c applied.
  - This is round-half-away-from-zero.
  - The product width is COEF_W+16 unsigned.
  - q is saturated to ±(2^(OUT_W-1)-1).
  - The most negative input magnitude is handled (|−128|=128).
- Simultaneous events:
  - A write completing bank A and a drain finishing bank B in the same edge are both honoured.
  - wr_bank==rd_bank while both are active cannot occur; in_ready is low whenever the write bank is full.
- Both banks full: in_ready=0 until the drain of rd_bank passes index 63.

Decomposition:
- Package jpeg_pkg holds:
  - ZZ_NAT[64], the 6-bit zigzag-to-natural index table.
  - QTAB_LUM[64], natural order.
  - RECIP_LUM[64] = round(2^16/Q), 16-bit.
  - The COEF_W and OUT_W defaults.
  - The block word width of 64.
- One sub-module, jpeg_quant_unit: combinational sign/magnitude multiply, round and saturate, taking coef and recip and returning the quantized value.
- Banks, counters and output register stay in the top.

Test Plan:
- Reset then idle → in_ready=1 and out_valid=0. reset asserted for 1 cycle mid-drain (zz=20) → out_valid=0 on the next cycle, and no further outputs until a new full block is written.
- Single block, all zero except row0 col0=64, row0 col1=22, row1 col0=36 → 64 outputs with idx 0..63 in order:
  - idx0=4, idx1=2, idx2=3, all others 0.
  - out_last only on idx63.
  - First out_valid on the cycle after row 7 is accepted.
- Rounding and sign: row0 col0=−24 (Q=16) → idx0=−2. row0 col0=−128 → −8. row0 col0=+8 → +1, since 0.5 rounds away from zero.
- Zigzag order: each coefficient at natural n set to a unique non-zero value v[n] → out_coef at idx k equals quant(v[ZZ_NAT[k]], QTAB_LUM[ZZ_NAT[k]]), compared against the package tables.
- Back-to-back: 4 blocks streamed with in_valid held high and out_ready=1 → 256 consecutive outputs with no bubble after the first; in_ready drops only while both banks are full.
- Backpressure: out_ready toggled with a pseudo-random 30% duty → no output lost or duplicated, out_coef stable while stalled, in_ready low while both banks are full, and the full output sequence equals the unstalled run.
